// File: rtl/pipelined_prefix_adder_pkg.sv
// adder_pkg: sizing helpers shared by the pipelined prefix adder.
// Level numbering: boundary position l sits after l prefix levels (l=0 is right after bitwise PG).
package adder_pkg;
    localparam int MAX_WIDTH = 64;

    function automatic int clog_valency(input int width, input int valency);
        int l;
        int span;
        l = 0;
        span = 1;
        while (span < width) begin
            span = span * valency;
            l++;
        end
        return l;
    endfunction

    function automatic int stage_level(input int j, input int stages, input int levels);
        return j * levels / stages;
    endfunction

    // Pipeline stage whose register sits at boundary position l, or 0 when l is unregistered.
    function automatic int stage_at(input int l, input int stages, input int levels);
        int r;
        r = 0;
        for (int j = 1; j < stages; j++)
            if (stage_level(j, stages, levels) == l) r = j;
        return r;
    endfunction
endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// pipelined_prefix_adder_if: operand and result valid/ready channels of the adder.
interface pipelined_prefix_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:1]   A;
    logic [WIDTH:1]   B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:1]   S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );
    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_prefix_adder_level.sv
// prefix_level: one combinational Kogge-Stone level of radix-VALENCY black/grey cells.
module prefix_level #(
    parameter int WIDTH   = 16,
    parameter int VALENCY = 2,
    parameter int LEVEL   = 0
) (
    input  logic [WIDTH:0] i_g,
    input  logic [WIDTH:0] i_p,
    output logic [WIDTH:0] o_g,
    output logic [WIDTH:0] o_p
);
    localparam int D = VALENCY ** LEVEL;

    // Node i merges the groups ending at i, i-D, i-2D, ... from high to low.
    always_comb begin
        o_g = i_g;
        o_p = i_p;
        for (int i = 0; i <= WIDTH; i++)
            for (int k = 1; k < VALENCY; k++)
                if (i >= k * D) begin
                    o_g[i] = o_g[i] | (o_p[i] & i_g[(i >= k * D) ? i - k * D : 0]);
                    o_p[i] = o_p[i] & i_p[(i >= k * D) ? i - k * D : 0];
                end
    end
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: radix-VALENCY Kogge-Stone add/subtract with PIPE_STAGES elastic stages.
// Bit 0 of the G/P words carries the effective carry-in (P0=0), folded in after the tree.
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int VALENCY     = 2,
    parameter int PIPE_STAGES = 2
) (
    input logic clk,
    input logic rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LEVELS = clog_valency(WIDTH, VALENCY);

    logic [PIPE_STAGES:1] r_v;
    logic [PIPE_STAGES:1] w_acc;
    logic [PIPE_STAGES:1] w_vin;
    logic [WIDTH:1]       w_bx;
    logic [WIDTH:0]       w_sg  [0:LEVELS];
    logic [WIDTH:0]       w_sp  [0:LEVELS];
    logic [WIDTH:1]       w_spb [0:LEVELS];
    logic [WIDTH:0]       w_dg  [0:LEVELS];
    logic [WIDTH:0]       w_dp  [0:LEVELS];
    logic [WIDTH:1]       w_dpb [0:LEVELS];
    logic [WIDTH:0]       w_c;
    logic [WIDTH:1]       r_s;
    logic                 r_cout;
    logic                 r_ovf;

    // A stage accepts when it or any later stage has a hole, or the consumer drains.
    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_hs
        assign w_acc[k] = bus.out_ready | ~(&r_v[PIPE_STAGES:k]);
        if (k == 1) begin : g_first
            assign w_vin[k] = bus.in_valid;
        end else begin : g_next
            assign w_vin[k] = r_v[k-1];
        end
    end

    assign bus.in_ready = w_acc[1] & ~rst;

    always_ff @(posedge clk)
        if (rst) r_v <= '0;
        else r_v <= (w_acc & w_vin) | (~w_acc & r_v);

    assign w_bx     = bus.sub ? ~bus.B : bus.B;
    assign w_sg[0]  = {bus.A & w_bx, bus.sub | bus.Cin};
    assign w_sp[0]  = {bus.A ^ w_bx, 1'b0};
    assign w_spb[0] = bus.A ^ w_bx;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int K = stage_at(l, PIPE_STAGES, LEVELS);
        if (K > 0) begin : g_reg
            logic [WIDTH:0] r_g;
            logic [WIDTH:0] r_p;
            logic [WIDTH:1] r_pb;
            always_ff @(posedge clk)
                if (w_acc[K] & w_vin[K]) begin
                    r_g  <= w_sg[l];
                    r_p  <= w_sp[l];
                    r_pb <= w_spb[l];
                end
            assign w_dg[l]  = r_g;
            assign w_dp[l]  = r_p;
            assign w_dpb[l] = r_pb;
        end else begin : g_wire
            assign w_dg[l]  = w_sg[l];
            assign w_dp[l]  = w_sp[l];
            assign w_dpb[l] = w_spb[l];
        end
        if (l < LEVELS) begin : g_pfx
            prefix_level #(.WIDTH(WIDTH), .VALENCY(VALENCY), .LEVEL(l)) u_level (
                .i_g (w_dg[l]),
                .i_p (w_dp[l]),
                .o_g (w_sg[l+1]),
                .o_p (w_sp[l+1])
            );
            assign w_spb[l+1] = w_dpb[l];
        end
    end

    // Top tree node spans bits WIDTH..1 at most, so fold the carry-in explicitly.
    assign w_c = w_dg[LEVELS] | (w_dp[LEVELS] & {(WIDTH+1){w_dg[LEVELS][0]}});

    always_ff @(posedge clk)
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_acc[PIPE_STAGES] & w_vin[PIPE_STAGES]) begin
            r_s    <= w_dpb[LEVELS] ^ w_c[WIDTH-1:0];
            r_cout <= w_c[WIDTH];
            r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end

    assign bus.out_valid = r_v[PIPE_STAGES];
    assign bus.S         = r_s;
    assign bus.Cout      = r_cout;
    assign bus.Ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: directed table plus handshake corner sequences for three adder configurations.
module tb_pipelined_prefix_adder;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    localparam int NV = 12;
    localparam int NS = 300;

    vec_t        vt [NV];
    logic        clk = 1'b0;
    logic        rst;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [65:0] q0 [$];
    logic [65:0] q1 [$];
    logic [65:0] q2 [$];

    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(16)) b0 ();
    pipelined_prefix_adder_if #(.WIDTH(33)) b1 ();
    pipelined_prefix_adder_if #(.WIDTH(8))  b2 ();

    pipelined_prefix_adder #(.WIDTH(16), .VALENCY(2), .PIPE_STAGES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pipelined_prefix_adder #(.WIDTH(33), .VALENCY(4), .PIPE_STAGES(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    pipelined_prefix_adder #(.WIDTH(8),  .VALENCY(2), .PIPE_STAGES(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic empty_pop(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: result with nothing outstanding at %0t", name, $time);
    endtask

    // Returns {ovf, cout, sum}; overflow from operand/result signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] m;
        logic [63:0] bx;
        logic [63:0] s;
        logic [64:0] t;
        logic        ovf;
        m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bx  = (sub ? ~b : b) & m;
        t   = {1'b0, a & m} + {1'b0, bx} + 65'(sub | cin);
        s   = t[63:0] & m;
        ovf = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
        return {ovf, t[w], s};
    endfunction

    task automatic drv0(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic v);
        b0.A = a;
        b0.B = b;
        b0.Cin = cin;
        b0.sub = sub;
        b0.in_valid = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [65:0] e;
        logic [15:0] held;
        logic        stalled;
        logic [15:0] ra [10];
        logic [15:0] rb [10];
        logic        rc [10];
        logic        rs [10];
        int          sent;
        int          got;
        logic [32:0] a1, bv1;
        logic [7:0]  a2, bv2;
        logic        ci1, sb1, ci2, sb2;
        int          sent1, got1, stall1, bub1, sent2, got2, stall2, bub2;

        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
        vt[10] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        vt[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1;
        drv0(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        b0.out_ready = 1'b1;
        {b1.A, b1.B, b1.Cin, b1.sub, b1.in_valid, b1.out_ready} = '0;
        {b2.A, b2.B, b2.Cin, b2.sub, b2.in_valid, b2.out_ready} = '0;
        repeat (2) @(negedge clk);

        // A beat offered while rst is high must be refused.
        drv0(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_in_ready", b0.in_ready, 0);
        chk("rst_out_valid", b0.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        b0.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", b0.in_ready, 1);
        chk("post_rst_out_valid", b0.out_valid, 0);
        chk("post_rst_S", b0.S, 0);
        chk("post_rst_Cout", b0.Cout, 0);
        chk("post_rst_Ovf", b0.Ovf, 0);

        // Isolated beats: exact two-cycle latency.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drv0(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1);
            #1;
            chk("lat_in_ready", b0.in_ready, 1);
            @(negedge clk);
            b0.in_valid = 1'b0;
            #1;
            chk("lat_early_valid", b0.out_valid, 0);
            @(negedge clk);
            #1;
            chk("lat_out_valid", b0.out_valid, 1);
            chk("lat_S", b0.S, vt[i].s);
            chk("lat_Cout", b0.Cout, vt[i].cout);
            chk("lat_Ovf", b0.Ovf, vt[i].ovf);
        end

        // Same table back-to-back: one result per cycle, in order.
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            if (i < NV) drv0(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1);
            else b0.in_valid = 1'b0;
            #1;
            if (i < NV) chk("stream_in_ready", b0.in_ready, 1);
            chk("stream_out_valid", b0.out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                chk("stream_S", b0.S, vt[i-2].s);
                chk("stream_Cout", b0.Cout, vt[i-2].cout);
                chk("stream_Ovf", b0.Ovf, vt[i-2].ovf);
            end
        end
        @(negedge clk);
        #1;
        chk("stream_drained", b0.out_valid, 0);

        // Backpressure: out_ready low for cycles 3..8 with in_valid held.
        for (int i = 0; i < 10; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rc[i] = 1'($urandom);
            rs[i] = 1'($urandom);
        end
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            b0.out_ready = !(c >= 3 && c <= 8);
            drv0(ra[sent % 10], rb[sent % 10], rc[sent % 10], rs[sent % 10], sent < 10);
            #1;
            if (stalled) chk("bp_S_stable", b0.S, held);
            if (c == 6) begin
                chk("bp_in_ready_low", b0.in_ready, 0);
                chk("bp_in_flight", q0.size(), 2);
            end
            if (b0.out_valid && b0.out_ready) begin
                if (q0.size() == 0) empty_pop("bp_extra_result");
                else begin
                    e = q0.pop_front();
                    chk("bp_result", {b0.Ovf, b0.Cout, b0.S}, {e[65], e[64], e[15:0]});
                end
                got++;
            end
            stalled = b0.out_valid && !b0.out_ready;
            held = b0.S;
            if (b0.in_valid && b0.in_ready) begin
                q0.push_back(model(16, 64'(ra[sent]), 64'(rb[sent]), rc[sent], rs[sent]));
                sent++;
            end
        end
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        chk("bp_count", got, 10);

        // Reset with two beats in flight: neither may ever appear.
        @(negedge clk);
        b0.out_ready = 1'b0;
        drv0(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drv0(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drv0(16'h0505, 16'h0606, 1'b0, 1'b0, 1'b1);
        #1;
        chk("mid_rst_in_ready", b0.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        #1;
        chk("mid_rst_out_valid", b0.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_dropped", b0.out_valid, 0);
        end
        @(negedge clk);
        drv0(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b1);
        #1;
        chk("after_rst_in_ready", b0.in_ready, 1);
        @(negedge clk);
        b0.in_valid = 1'b0;
        #1;
        chk("after_rst_early", b0.out_valid, 0);
        @(negedge clk);
        #1;
        chk("after_rst_valid", b0.out_valid, 1);
        chk("after_rst_S", b0.S, 16'h0123);

        // Parameter sweep: 33/4/4 and 8/2/1 streams, full rate then random backpressure.
        a1 = 33'({$urandom, $urandom});
        bv1 = 33'({$urandom, $urandom});
        {ci1, sb1} = 2'($urandom);
        a2 = 8'($urandom);
        bv2 = 8'($urandom);
        {ci2, sb2} = 2'($urandom);
        {sent1, got1, stall1, bub1, sent2, got2, stall2, bub2} = '0;
        for (int c = 0; c < 2000 && (got1 < NS || got2 < NS); c++) begin
            @(negedge clk);
            b1.out_ready = (c < 150) || ($urandom_range(0, 3) != 0);
            b2.out_ready = (c < 150) || ($urandom_range(0, 3) != 0);
            b1.in_valid = sent1 < NS;
            b1.A = a1;
            b1.B = bv1;
            b1.Cin = ci1;
            b1.sub = sb1;
            b2.in_valid = sent2 < NS;
            b2.A = a2;
            b2.B = bv2;
            b2.Cin = ci2;
            b2.sub = sb2;
            #1;
            if (c < 150 && !b1.in_ready) stall1++;
            if (c >= 4 && c < 150 && !b1.out_valid) bub1++;
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) empty_pop("sweep33_extra");
                else begin
                    e = q1.pop_front();
                    chk("sweep33_result", {b1.Ovf, b1.Cout, b1.S}, {e[65], e[64], e[32:0]});
                end
                got1++;
            end
            if (b1.in_valid && b1.in_ready) begin
                q1.push_back(model(33, 64'(a1), 64'(bv1), ci1, sb1));
                sent1++;
                a1 = ($urandom_range(0, 7) == 0) ? '1 : 33'({$urandom, $urandom});
                bv1 = ($urandom_range(0, 7) == 0) ? '0 : 33'({$urandom, $urandom});
                {ci1, sb1} = 2'($urandom);
            end
            if (c < 150 && !b2.in_ready) stall2++;
            if (c >= 1 && c < 150 && !b2.out_valid) bub2++;
            if (b2.out_valid && b2.out_ready) begin
                if (q2.size() == 0) empty_pop("sweep8_extra");
                else begin
                    e = q2.pop_front();
                    chk("sweep8_result", {b2.Ovf, b2.Cout, b2.S}, {e[65], e[64], e[7:0]});
                end
                got2++;
            end
            if (b2.in_valid && b2.in_ready) begin
                q2.push_back(model(8, 64'(a2), 64'(bv2), ci2, sb2));
                sent2++;
                a2 = 8'($urandom);
                bv2 = 8'($urandom);
                {ci2, sb2} = 2'($urandom);
            end
        end
        chk("sweep33_count", got1, NS);
        chk("sweep33_stalls", stall1, 0);
        chk("sweep33_bubbles", bub1, 0);
        chk("sweep8_count", got2, NS);
        chk("sweep8_stalls", stall2, 0);
        chk("sweep8_bubbles", bub2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
